// File: rtl/contador_bcd_cascada.sv
// Multi-digit modulo-BASE up/down counter (BCD when BASE=10) with parallel load,
// combinational cascade carry/borrow, registered wrap pulse and sticky load error flag.
module contador_bcd_cascada #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BASE   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                carry_out,
  output logic                wrap,
  output logic                load_err
);

  localparam logic [3:0] BaseNib  = 4'(BASE);
  localparam logic [3:0] MaxDigit = 4'(BASE - 1);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic                wrap_q;
  logic                err_q, err_d;
  logic                all_max, all_zero;
  logic                step;
  logic [3:0]          dig;

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cnt_q[4*i +: 4] != MaxDigit) all_max = 1'b0;
      if (cnt_q[4*i +: 4] != 4'd0)     all_zero = 1'b0;
    end
  end

  // Zero-latency so chained stages all step on the same edge.
  assign carry_out = en & ~load & ~rst & (up ? all_max : all_zero);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    step  = 1'b1;
    dig   = 4'd0;
    if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = load_val[4*i +: 4];
        if (dig >= BaseNib) begin
          dig   = 4'd0;
          err_d = 1'b1;
        end
        cnt_d[4*i +: 4] = dig;
      end
    end else if (en) begin
      // step ripples up while every lower digit sits at its terminal value.
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = cnt_q[4*i +: 4];
        if (step) begin
          if (up) cnt_d[4*i +: 4] = (dig == MaxDigit) ? 4'd0 : dig + 4'd1;
          else    cnt_d[4*i +: 4] = (dig == 4'd0) ? MaxDigit : dig - 4'd1;
        end
        step = step & (up ? (dig == MaxDigit) : (dig == 4'd0));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= carry_out;
      err_q  <= err_d;
    end
  end

  assign q        = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_contador_bcd_cascada.sv
// Scoreboard bench: a 2-digit BCD counter, a 1-digit mod-6 counter and two chained
// 2-digit BCD stages, all checked against an integer-valued reference model.
module tb_contador_bcd_cascada;

  typedef struct packed {
    logic [15:0] q;
    logic        c;
    logic        w;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] lv;

  logic [7:0] q_m;
  logic       c_m, w_m, e_m;
  logic [3:0] q_s;
  logic       c_s, w_s, e_s;
  logic [7:0] q_a, q_b;
  logic       c_a, w_a, e_a, c_b, w_b, e_b;

  always #5 clk = ~clk;

  contador_bcd_cascada #(.DIGITS(2), .BASE(10)) dut_m (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q_m), .carry_out(c_m), .wrap(w_m), .load_err(e_m)
  );

  contador_bcd_cascada #(.DIGITS(1), .BASE(6)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .q(q_s), .carry_out(c_s), .wrap(w_s), .load_err(e_s)
  );

  contador_bcd_cascada #(.DIGITS(2), .BASE(10)) cas_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .q(q_a), .carry_out(c_a), .wrap(w_a), .load_err(e_a)
  );

  contador_bcd_cascada #(.DIGITS(2), .BASE(10)) cas_b (
    .clk(clk), .rst(rst), .en(c_a), .up(up), .load(load), .load_val(lv[15:8]),
    .q(q_b), .carry_out(c_b), .wrap(w_b), .load_err(e_b)
  );

  // Model lanes: 0 = 2-digit BCD, 1 = 1-digit mod 6, 2 = cascade seen as 4-digit BCD.
  int   md[3] = '{2, 1, 4};
  int   mb[3] = '{10, 6, 10};
  int   mn[3] = '{0, 0, 0};
  bit   mw[3] = '{0, 0, 0};
  bit   me[3] = '{0, 0, 0};
  exp_t sb0[$], sb1[$], sb2[$];

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [15:0] to_vec(input int n, input int d, input int b);
    logic [15:0] v;
    int          r;
    v = '0;
    r = n;
    for (int i = 0; i < d; i++) begin
      v[4*i +: 4] = 4'(r % b);
      r = r / b;
    end
    return v;
  endfunction

  task automatic model_lane(input int k);
    int   m, acc, pw, dg;
    bit   c;
    exp_t x;
    m = 1;
    for (int i = 0; i < md[k]; i++) m = m * mb[k];
    c = en && !load && !rst && (up ? (mn[k] == m - 1) : (mn[k] == 0));
    x.q = to_vec(mn[k], md[k], mb[k]);
    x.c = c;
    x.w = mw[k];
    x.e = me[k];
    case (k)
      0:       sb0.push_back(x);
      1:       sb1.push_back(x);
      default: sb2.push_back(x);
    endcase
    if (rst) begin
      mn[k] = 0;
      mw[k] = 1'b0;
      me[k] = 1'b0;
    end else begin
      mw[k] = c;
      if (load) begin
        acc = 0;
        pw  = 1;
        for (int i = 0; i < md[k]; i++) begin
          dg = int'(lv[4*i +: 4]);
          if (dg >= mb[k]) begin
            me[k] = 1'b1;
            dg    = 0;
          end
          acc = acc + dg * pw;
          pw  = pw * mb[k];
        end
        mn[k] = acc;
      end else if (en) begin
        mn[k] = up ? (mn[k] + 1) % m : (mn[k] + m - 1) % m;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [15:0] v);
    @(posedge clk);
    #1;
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    lv   = v;
    for (int k = 0; k < 3; k++) model_lane(k);
  endtask

  task automatic check(input string name, input exp_t x, input logic [15:0] aq,
                       input logic ac, input logic aw, input logic ae);
    compared++;
    if (aq !== x.q || ac !== x.c || aw !== x.w || ae !== x.e) begin
      mismatched++;
      $display("FAIL %s @%0t: got q=%h carry=%b wrap=%b err=%b, want q=%h carry=%b wrap=%b err=%b",
               name, $time, aq, ac, aw, ae, x.q, x.c, x.w, x.e);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb0.size() > 0) begin
      x = sb0.pop_front();
      check("bcd2", x, {8'h00, q_m}, c_m, w_m, e_m);
    end
    if (sb1.size() > 0) begin
      x = sb1.pop_front();
      check("mod6", x, {12'h000, q_s}, c_s, w_s, e_s);
    end
    if (sb2.size() > 0) begin
      x = sb2.pop_front();
      check("cascade", x, {q_b, q_a}, c_b, w_b, e_a | e_b);
    end
  end

  initial begin
    logic        rr, ll, ee, uu;
    logic [15:0] vv;
    rst  = 1'b1;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    lv   = '0;
    @(posedge clk);
    // Reset beats load and enable.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0057);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    // Long up count: every wrap of the 2-digit stages and one full cascade wrap.
    repeat (10001) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    // Down from zero borrows immediately.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    // Invalid digit on load, then sticky error through a valid load.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h3A3A);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h1212);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    // Hold.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h4242);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    // Reset mid-count, then resume.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    // Randomised traffic, biased toward terminal values to hit wraps.
    repeat (2000) begin
      rr = ($urandom_range(0, 49) == 0);
      ll = ($urandom_range(0, 9) == 0);
      ee = ($urandom_range(0, 3) != 0);
      uu = 1'($urandom_range(0, 1));
      vv = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       vv = 16'h9999;
        1:       vv = 16'h0000;
        2:       vv = 16'h9955;
        default: ;
      endcase
      cyc(rr, ee, uu, ll, vv);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (sb0.size() != 0 || sb1.size() != 0 || sb2.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d/%0d entries left, want 0/0/0",
               sb0.size(), sb1.size(), sb2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
